// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register: FSM state encoding and occupancy width.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    localparam int OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_t s);
        case (s)
            BUSY:    return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload+control holding register with load enable; optionally cleared by reset and clr.
module pipe_slot #(
    parameter int W   = 48,
    parameter bit CLR = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (CLR) begin : g_clr
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= '0;
                else if (clr)
                    q <= '0;
                else if (load)
                    q <= d;
            end
        end else begin : g_hold
            // Payload-only storage: no reset, so the slot stays a plain enable flop.
            logic unused_ctl;
            assign unused_ctl = &{1'b0, rst_n, clr};

            always_ff @(posedge clk) begin
                if (load)
                    q <= d;
            end
        end
    endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: valid/ready handshake, 2-entry skid, flush, occupancy.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 16,
    parameter bit CLR_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int W = DATA_W + CTRL_W;

    pipe_state_t state, state_nxt;
    logic        accept, issue;
    logic        main_ld, skid_ld, main_from_skid;
    logic [W-1:0] main_d, main_q, skid_q;

    assign accept = in_valid & in_ready;
    assign issue  = out_valid & out_ready;
    assign main_d = main_from_skid ? skid_q : {in_data, in_ctrl};

    pipe_slot #(.W(W), .CLR(CLR_DATA)) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .load  (main_ld),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(.W(W), .CLR(CLR_DATA)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .load  (skid_ld),
        .d     ({in_data, in_ctrl}),
        .q     (skid_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Flush wins over every transfer; an issue in the flush cycle needs no action here.
    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = BUSY;
                        main_ld   = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && issue) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_ld   = 1'b1;
                    end else if (issue) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (issue) begin
                        state_nxt      = BUSY;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // All outputs decode from registered state, so nothing depends on out_ready combinationally.
    always_comb begin
        in_ready  = (state != FULL);
        out_valid = (state != EMPTY);
        out_data  = main_q[W-1:CTRL_W];
        out_ctrl  = out_valid ? main_q[CTRL_W-1:0] : '0;
        occupancy = occ_of(state);
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues accepted entries, negedge monitor checks.
module tb_pipe_stage_reg;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W+CTRL_W-1:0] sb[$];
    int                       occ = 0;
    logic                     hold_chk = 1'b0;
    logic [DATA_W-1:0]        prev_data;
    logic [CTRL_W-1:0]        prev_ctrl;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLR_DATA(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the entry is queued only if this edge will accept it.
    task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                        input logic f, input logic r);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        flush     = f;
        out_ready = r;
        @(negedge clk);
        if (v && in_ready && !f && rst_n)
            sb.push_back({d, c});
    endtask

    always @(negedge clk) begin
        logic [DATA_W+CTRL_W-1:0] e;
        logic acc, iss;
        if (!rst_n) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_occupancy", 64'(occupancy), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
            occ = 0;
            sb.delete();
            hold_chk = 1'b0;
        end else begin
            chk("occupancy", 64'(occupancy), 64'(occ));
            chk("in_ready", 64'(in_ready), 64'(occ != 2));
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            if (!out_valid)
                chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
            if (hold_chk) begin
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_ctrl", 64'(out_ctrl), 64'(prev_ctrl));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output actual=%0h/%0h expected=none at %0t",
                             out_data, out_ctrl, $time);
                end else begin
                    e = sb.pop_front();
                    if ({out_data, out_ctrl} !== e) begin
                        errors++;
                        $display("FAIL order actual=%0h/%0h expected=%0h/%0h at %0t",
                                 out_data, out_ctrl, e[DATA_W+CTRL_W-1:CTRL_W],
                                 e[CTRL_W-1:0], $time);
                    end
                end
            end
            iss       = (occ != 0) && out_ready;
            acc       = in_valid && (occ != 2);
            hold_chk  = (occ != 0) && !out_ready && !flush;
            prev_data = out_data;
            prev_ctrl = out_ctrl;
            if (flush) begin
                occ = 0;
                sb.delete();
            end else begin
                occ = occ + int'(acc) - int'(iss);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Streaming 1..8 at full rate
        for (int i = 1; i <= 8; i++)
            step(1'b1, DATA_W'(i), 16'hFFFF, 1'b0, 1'b1);
        repeat (2) step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);

        // Stall with 0xA then 0xB, three stalled cycles, then release
        step(1'b1, 32'hA, 16'hFFFF, 1'b0, 1'b0);
        step(1'b1, 32'hB, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, '0, 16'hFFFF, 1'b0, 1'b0);
        step(1'b1, 32'hEE, 16'hFFFF, 1'b0, 1'b0);
        repeat (3) step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);

        // Flush while FULL with a competing input 0xC
        step(1'b1, 32'h1, 16'hFFFF, 1'b0, 1'b0);
        step(1'b1, 32'h2, 16'hFFFF, 1'b0, 1'b0);
        step(1'b1, 32'hC, 16'hFFFF, 1'b1, 1'b0);
        repeat (2) step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);

        // Flush in BUSY while the head entry issues
        step(1'b1, 32'h5, 16'h1234, 1'b0, 1'b1);
        step(1'b1, 32'h6, 16'h1234, 1'b1, 1'b1);
        step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);

        // Asynchronous reset while FULL and stalled
        step(1'b1, 32'h7, 16'hFFFF, 1'b0, 1'b0);
        step(1'b1, 32'h8, 16'hFFFF, 1'b0, 1'b0);
        step(1'b0, '0, 16'hFFFF, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(out_valid), 64'd0);
        chk("async_occupancy", 64'(occupancy), 64'd0);
        chk("async_out_ctrl", 64'(out_ctrl), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'd1);
        repeat (2) step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);

        // Randomised traffic with occasional flush
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, $urandom, 16'($urandom),
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
        repeat (4) step(1'b0, '0, 16'hFFFF, 1'b0, 1'b1);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
